// File: rtl/ir_prefetch_queue.sv
// Purpose: instruction register fed by a DEPTH-entry prefetch FIFO; operand field driven onto a tri-state bus.
// Latency: LOAD -> FIFO 1 clk, ADVANCE -> IR 1 clk, ENABLE -> DATA_OUT 1 clk (registered).
// Backpressure: LOAD while FULL without ADVANCE is dropped and sets sticky OVERFLOW. Optional: `define IR_BYPASS_EN.
module ir_prefetch_queue #(
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic                       LOAD,
    input  logic [BUS_WIDTH-1:0]       DATA_IN,
    input  logic                       ADVANCE,
    input  logic                       FLUSH,
    input  logic                       ENABLE,
    output logic [BUS_WIDTH-1:0]       DATA_OUT,
    output logic [BUS_WIDTH-1:0]       INSTRUCTION_OUT,
    output logic                       INSTR_VALID,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic                       OVERFLOW
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [BUS_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [BUS_WIDTH-1:0] ir_q, ir_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic [BUS_WIDTH-1:0] dout_q, dout_d;
    logic                 oe_q, oe_d;
    logic                 push, pop, is_empty, is_full;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LVL_W'(DEPTH));

    // Next-state for queue pointers, occupancy, IR and sticky overflow.
    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        if (FLUSH) begin
            // Jump/branch: drop everything queued, keep IR bits but mark them stale.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            valid_d  = 1'b0;
        end else begin
            if (ADVANCE) begin
                if (!is_empty) begin
                    pop     = 1'b1;
                    ir_d    = mem_q[rd_ptr_q];
                    valid_d = 1'b1;
                end else begin
`ifdef IR_BYPASS_EN
                    if (LOAD) begin
                        ir_d    = DATA_IN;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
`else
                    valid_d = 1'b0;
`endif
                end
            end
            // A same-cycle pop frees the slot, so a full queue can still accept.
            if (LOAD) begin
`ifdef IR_BYPASS_EN
                if (ADVANCE && is_empty) begin
                    push = 1'b0;
                end else
`endif
                if (!is_full || pop) begin
                    push = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Bus driver: operand of the IR as it stood before this edge, independent of FLUSH.
    always_comb begin
        oe_d   = ENABLE;
        dout_d = '0;
        if (ENABLE) dout_d = {{(BUS_WIDTH-ADDR_WIDTH){1'b0}}, ir_q[ADDR_WIDTH-1:0]};
    end

    // Control and IR state registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ir_q     <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dout_q   <= '0;
            oe_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLOCK) begin
        if (!RESET && push) mem_q[wr_ptr_q] <= DATA_IN;
    end

    assign DATA_OUT        = oe_q ? dout_q : {BUS_WIDTH{1'bz}};
    assign INSTRUCTION_OUT = ir_q;
    assign INSTR_VALID     = valid_q;
    assign FULL            = is_full;
    assign EMPTY           = is_empty;
    assign LEVEL           = level_q;
    assign OVERFLOW        = ovf_q;
endmodule

// File: tb/tb_ir_prefetch_queue.sv
module tb_ir_prefetch_queue;
    localparam int DEPTH = 4;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        LOAD = 1'b0, ADVANCE = 1'b0, FLUSH = 1'b0, ENABLE = 1'b0;
    logic [15:0] DATA_IN = '0;
    logic [15:0] DATA_OUT, INSTRUCTION_OUT;
    logic        INSTR_VALID, FULL, EMPTY, OVERFLOW;
    logic [2:0]  LEVEL;

    ir_prefetch_queue #(.BUS_WIDTH(16), .ADDR_WIDTH(12), .DEPTH(DEPTH)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .LOAD(LOAD), .DATA_IN(DATA_IN),
        .ADVANCE(ADVANCE), .FLUSH(FLUSH), .ENABLE(ENABLE), .DATA_OUT(DATA_OUT),
        .INSTRUCTION_OUT(INSTRUCTION_OUT), .INSTR_VALID(INSTR_VALID), .FULL(FULL),
        .EMPTY(EMPTY), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Reference model: a plain queue plus the architected registers.
    logic [15:0] mq[$];
    logic [15:0] m_ir;
    logic        m_valid, m_ovf;
    logic [15:0] m_dout;
    logic [15:0] zz = 16'hzzzz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic ld, input logic [15:0] din,
                              input logic adv, input logic fl, input logic en);
        if (rst) begin
            mq.delete();
            m_ir = '0; m_valid = 1'b0; m_ovf = 1'b0; m_dout = zz;
        end else begin
            m_dout = en ? {4'h0, m_ir[11:0]} : zz;
            if (fl) begin
                mq.delete();
                m_valid = 1'b0;
            end else if (adv) begin
                if (mq.size() > 0) begin
                    m_ir = mq.pop_front();
                    m_valid = 1'b1;
                    if (ld) mq.push_back(din);
                end else if (ld) begin
`ifdef IR_BYPASS_EN
                    m_ir = din; m_valid = 1'b1;
`else
                    mq.push_back(din); m_valid = 1'b0;
`endif
                end else begin
                    m_valid = 1'b0;
                end
            end else if (ld) begin
                if (mq.size() < DEPTH) mq.push_back(din);
                else m_ovf = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, settle to the falling edge.
    task automatic cycle(input logic rst, input logic ld, input logic [15:0] din,
                         input logic adv, input logic fl, input logic en);
        RESET = rst; LOAD = ld; DATA_IN = din; ADVANCE = adv; FLUSH = fl; ENABLE = en;
        @(posedge CLOCK);
        model_edge(rst, ld, din, adv, fl, en);
        check_en = 1'b1;
        @(negedge CLOCK);
        #1;
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge CLOCK) begin
        if (check_en) begin
            chk("ir",       INSTRUCTION_OUT, m_ir);
            chk("valid",    INSTR_VALID,     m_valid);
            chk("level",    LEVEL,           mq.size());
            chk("full",     FULL,            mq.size() == DEPTH);
            chk("empty",    EMPTY,           mq.size() == 0);
            chk("overflow", OVERFLOW,        m_ovf);
            chk("data_out", DATA_OUT,        m_dout);
        end
    end

    logic [15:0] seq1 [4] = '{16'h1234, 16'h2345, 16'h3456, 16'h4567};
    logic [15:0] seq2 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] seq3 [4] = '{16'h2222, 16'h3333, 16'h4444, 16'hAAAA};

    initial begin
        @(negedge CLOCK);
        // Reset for two clocks.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("rst_valid", INSTR_VALID, 0);
        chk("rst_level", LEVEL, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_ovf",   OVERFLOW, 0);
        chk("rst_dout",  DATA_OUT, zz);

        // Fill, overflow, drain in order.
        for (int i = 0; i < 4; i++) cycle(0, 1, seq1[i], 0, 0, 0);
        chk("fill_full", FULL, 1);
        cycle(0, 1, 16'h5678, 0, 0, 0);
        chk("ovf_set",   OVERFLOW, 1);
        chk("ovf_level", LEVEL, 4);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1, 0, 0);
            chk("drain_ir", INSTRUCTION_OUT, seq1[i]);
        end
        chk("drain_empty", EMPTY, 1);

        // Simultaneous load and advance on a full queue, then wrap-around drain.
        for (int i = 0; i < 4; i++) cycle(0, 1, seq2[i], 0, 0, 0);
        cycle(0, 1, 16'hAAAA, 1, 0, 0);
        chk("la_ir",    INSTRUCTION_OUT, 16'h1111);
        chk("la_level", LEVEL, 4);
        chk("la_ovf",   OVERFLOW, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1, 0, 0);
            chk("wrap_ir", INSTRUCTION_OUT, seq3[i]);
        end

        // Operand onto the bus.
        cycle(0, 1, 16'hF123, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        chk("bus_on",  DATA_OUT, 16'h0123);
        cycle(0, 0, 0, 0, 0, 0);
        chk("bus_off", DATA_OUT, zz);

        // Flush beats load and advance.
        for (int i = 0; i < 3; i++) cycle(0, 1, 16'h0A00 + 16'(i), 0, 0, 0);
        cycle(0, 1, 16'h7777, 1, 1, 0);
        chk("fl_level", LEVEL, 0);
        chk("fl_valid", INSTR_VALID, 0);
        chk("fl_ir",    INSTRUCTION_OUT, 16'hF123);
        cycle(0, 0, 0, 1, 0, 0);
        chk("fl_bubble", INSTR_VALID, 0);

        // Load and advance on an empty queue.
        cycle(0, 1, 16'hBEEF, 1, 0, 0);
`ifdef IR_BYPASS_EN
        chk("byp_ir",    INSTRUCTION_OUT, 16'hBEEF);
        chk("byp_valid", INSTR_VALID, 1);
        chk("byp_level", LEVEL, 0);
`else
        chk("nobyp_level", LEVEL, 1);
        chk("nobyp_valid", INSTR_VALID, 0);
        cycle(0, 0, 0, 1, 0, 0);
        chk("nobyp_ir", INSTRUCTION_OUT, 16'hBEEF);
`endif

        // Reset mid-stream discards queued words.
        cycle(0, 1, 16'h1357, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        chk("rst_mid_valid", INSTR_VALID, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom % 250) == 0, $urandom % 2, 16'($urandom),
                  ($urandom % 3) == 0, ($urandom % 20) == 0, $urandom % 2);
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
